// File: rtl/div_seq_ctrl.sv
// Sequencer around the iterative divider core: operand magnitudes, iteration count, sign fix-up.
// Optional DIV_ZERO_TRAP_EN: flag divide-by-zero and keep previous LO/HI instead of writing them.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] core_q,
  output logic [WIDTH-1:0] core_m,
  output logic             core_load,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_accept;
  logic             w_zero;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_core_q;
  logic [WIDTH-1:0] r_core_m;
  logic [WIDTH-1:0] r_dividend;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_zero   = (r_core_m == '0);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Divide-by-zero still passes through FIX so both paths end on the same edge of LO/HI update.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_PREP;
      S_PREP: begin
        if (w_zero) begin
          w_next = S_FIX;
        end else begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN:  if (r_cnt == CW'(ITERS - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = start ? S_PREP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_core_q   <= '0;
      r_core_m   <= '0;
      r_dividend <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_core_q   <= (div_signed & dividend[WIDTH-1]) ? -dividend : dividend;
      r_core_m   <= (div_signed & divisor[WIDTH-1]) ? -divisor : divisor;
      r_dividend <= dividend;
      r_q_neg    <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_r_neg    <= div_signed & dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)               r_cnt <= '0;
    else if (r_state == S_PREP) r_cnt <= '0;
    else if (r_state == S_RUN)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_lo_fix = r_q_neg ? -core_quotient : core_quotient;
  assign w_hi_fix = r_r_neg ? -core_remainder : core_remainder;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (r_state == S_FIX) begin
      if (!w_zero) begin
        r_lo <= w_lo_fix;
        r_hi <= w_hi_fix;
      end else begin
`ifndef DIV_ZERO_TRAP_EN
        r_lo <= '1;
        r_hi <= r_dividend;
`endif
      end
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic r_dbz;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                        r_dbz <= 1'b0;
    else if (w_accept)                   r_dbz <= 1'b0;
    else if ((r_state == S_FIX) & w_zero) r_dbz <= 1'b1;
  end

  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  assign core_q    = r_core_q;
  assign core_m    = r_core_m;
  assign core_load = w_load;
  assign busy      = (r_state == S_PREP) | (r_state == S_RUN) | (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign lo_out    = r_lo;
  assign hi_out    = r_hi;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl with a behavioural iterative core.
// Vector table for single divides plus sequences for restart, back-to-back and reset.
module tb_div_seq_ctrl;

  localparam int W = 32;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         start = 1'b0;
  logic         div_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] core_q;
  logic [W-1:0] core_m;
  logic         core_load;
  logic [W-1:0] core_quotient;
  logic [W-1:0] core_remainder;
  logic         busy;
  logic         done;
  logic [W-1:0] lo_out;
  logic [W-1:0] hi_out;
  logic         div_by_zero;

  div_seq_ctrl #(.WIDTH(W), .ITERS(N)) dut (
    .clk(clk), .clear_n(clear_n), .start(start),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .core_q(core_q), .core_m(core_m), .core_load(core_load),
    .core_quotient(core_quotient), .core_remainder(core_remainder),
    .busy(busy), .done(done), .lo_out(lo_out), .hi_out(hi_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Core model: results appear only once N edges have passed since the load edge.
  logic [W-1:0] m_q, m_r;
  int           m_cnt;
  logic         m_vld;

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_cnt <= 0;
      m_vld <= 1'b0;
      m_q   <= '0;
      m_r   <= '0;
    end else if (core_load) begin
      m_q   <= (core_m != 0) ? core_q / core_m : '1;
      m_r   <= (core_m != 0) ? core_q % core_m : '1;
      m_cnt <= N;
      m_vld <= 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_quotient  = (m_vld && m_cnt == 0) ? m_q : 32'hDEAD_BEEF;
  assign core_remainder = (m_vld && m_cnt == 0) ? m_r : 32'hBAAD_F00D;

  int loads;
  always @(negedge clk) if (core_load) loads++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic go(input bit at_neg, input logic s,
                    input logic [W-1:0] a, input logic [W-1:0] b);
    if (at_neg) @(negedge clk);
    loads      = 0;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'h5A5A_5A5A;
    divisor  = 32'hA5A5_A5A5;
    div_signed = ~s;
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input int poke, output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int i = 1; i <= 100 && !got; i++) begin
      if (i == poke) begin
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        got = 1;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout actual=no_done required=done");
    end
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
  } vec_t;

  vec_t vt[8];
  int   lat;
  logic [W-1:0] prev_lo, prev_hi, exp_lo, exp_hi;
  logic         exp_dbz;

  initial begin
    vt[0] = '{1'b0, 32'd50,        32'd7,         32'd7,         32'd1,         34};
    vt[1] = '{1'b1, 32'hFFFF_FFCE, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 34};
    vt[2] = '{1'b1, 32'd100,       32'hFFFF_FFFA, 32'hFFFF_FFF0, 32'd4,         34};
    vt[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         34};
    vt[4] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    vt[5] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34};
    vt[6] = '{1'b0, 32'd11,        32'd0,         32'hFFFF_FFFF, 32'd11,        2};
    vt[7] = '{1'b1, 32'hFFFF_FFF5, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF5, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_q", core_q, 0);
    chk("rst_core_m", core_m, 0);
    chk("rst_ctl", {29'd0, core_load, busy, done}, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk);
    clear_n = 1'b1;

    prev_lo = '0;
    prev_hi = '0;
    for (int k = 0; k < 8; k++) begin
      exp_lo  = vt[k].lo;
      exp_hi  = vt[k].hi;
      exp_dbz = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      if (vt[k].b == 0) begin
        exp_lo  = prev_lo;
        exp_hi  = prev_hi;
        exp_dbz = 1'b1;
      end
`endif
      go(1'b1, vt[k].s, vt[k].a, vt[k].b);
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, 1);
      wait_done(0, lat);
      chk($sformatf("v%0d_lat", k), lat, vt[k].lat);
      chk($sformatf("v%0d_lo", k), lo_out, exp_lo);
      chk($sformatf("v%0d_hi", k), hi_out, exp_hi);
      chk($sformatf("v%0d_dbz", k), {31'd0, div_by_zero}, {31'd0, exp_dbz});
      chk($sformatf("v%0d_busy_done", k), {31'd0, busy}, 0);
      chk($sformatf("v%0d_loads", k), loads, (vt[k].b == 0) ? 0 : 1);
      prev_lo = exp_lo;
      prev_hi = exp_hi;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", k), {31'd0, done}, 0);
    end

    // Start re-pulsed at RUN cycle 10 must be ignored.
    go(1'b1, 1'b0, 32'd50, 32'd7);
    wait_done(11, lat);
    chk("repulse_lat", lat, 34);
    chk("repulse_lo", lo_out, 7);
    chk("repulse_hi", hi_out, 1);
    chk("repulse_loads", loads, 1);

    // Back-to-back: start during the DONE cycle.
    go(1'b0, 1'b1, 32'd100, 32'hFFFF_FFFA);
    chk("b2b_hold_lo", lo_out, 7);
    wait_done(0, lat);
    chk("b2b_lat", lat, 34);
    chk("b2b_lo", lo_out, 32'hFFFF_FFF0);
    chk("b2b_hi", hi_out, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_lo", lo_out, 32'hFFFF_FFF0);
    chk("hold_hi", hi_out, 4);

    // Reset during RUN cycle 5 abandons the divide.
    go(1'b1, 1'b0, 32'd50, 32'd7);
    repeat (6) @(posedge clk);
    #1;
    clear_n = 1'b0;
    #1;
    chk("mid_rst_core_q", core_q, 0);
    chk("mid_rst_core_m", core_m, 0);
    chk("mid_rst_ctl", {29'd0, core_load, busy, done}, 0);
    chk("mid_rst_lo", lo_out, 0);
    chk("mid_rst_hi", hi_out, 0);
    @(negedge clk);
    clear_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done || busy) seen++;
      end
      chk("mid_rst_no_done", seen, 0);
    end
    go(1'b1, 1'b1, 32'hFFFF_FFCE, 32'd7);
    wait_done(0, lat);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_lo", lo_out, 32'hFFFF_FFF9);
    chk("post_rst_hi", hi_out, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
